minmax_tracker: RTL



---
 rtl/minmax_pkg.sv | 14 +
 rtl/mag_cmp.sv | 18 +
 rtl/minmax_tracker.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/minmax_pkg.sv
// Shared types and default widths for the frame min/max statistics stage.
// The optional index outputs of minmax_tracker are enabled with MINMAX_INDEX_EN.
package minmax_pkg;

    localparam int N_DEF     = 32;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/mag_cmp.sv
// Combinational unsigned magnitude comparator: a against b over the full width.
module mag_cmp #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         gr,
    output logic         lo,
    output logic         eq
);

    always_comb begin
        gr = (a > b);
        lo = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/minmax_tracker.sv
// Per-frame running max/min/count over a valid/ready sample stream, one result beat per frame.
// Define MINMAX_INDEX_EN to add out_max_idx/out_min_idx (first-occurrence positions).
//
// Handshake: a beat moves on a rising edge where valid && ready; valid never waits on
// ready, and a producer holding valid keeps its payload stable until the transfer.
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_max,
    output logic [N-1:0]     out_min,
    output logic [CNT_W-1:0] out_cnt,
`ifdef MINMAX_INDEX_EN
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_min_idx,
`endif
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q;
    logic               rdy_q;
    logic               out_valid_q;
    logic [N-1:0]       max_q, min_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N-1:0]       out_max_q, out_min_q;
    logic [CNT_W-1:0]   out_cnt_q;

    logic [N-1:0]       max_d, min_d;
    logic [CNT_W-1:0]   cnt_d;

    logic               max_gr, max_lo, max_eq;
    logic               min_gr, min_lo, min_eq;
    logic               accept, first, close;

    mag_cmp #(.N(N)) u_cmp_max (
        .a  (in_data),
        .b  (max_q),
        .gr (max_gr),
        .lo (max_lo),
        .eq (max_eq)
    );

    mag_cmp #(.N(N)) u_cmp_min (
        .a  (in_data),
        .b  (min_q),
        .gr (min_gr),
        .lo (min_lo),
        .eq (min_eq)
    );

    // rst_n gates ready so nothing is offered while reset is asserted.
    assign in_ready  = rdy_q & rst_n;
    assign accept    = in_valid & in_ready;
    assign first     = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_min   = out_min_q;
    assign out_cnt   = out_cnt_q;
    assign dbg_state = state_q;

    // Equal samples keep the stored extremum, so ties retain the earliest one.
    always_comb begin
        max_d = (first || !(max_eq || max_lo)) ? in_data : max_q;
        min_d = (first || !(min_eq || min_gr)) ? in_data : min_q;
        cnt_d = first ? CNT_W'(1) : cnt_q + 1'b1;
        close = accept && (in_last || (cnt_d == CNT_MAX));
    end

`ifdef MINMAX_INDEX_EN
    logic [CNT_W-1:0] max_idx_q, min_idx_q;
    logic [CNT_W-1:0] max_idx_d, min_idx_d;
    logic [CNT_W-1:0] out_max_idx_q, out_min_idx_q;

    // cnt_q is the number of samples already held, i.e. the position of the new one.
    always_comb begin
        max_idx_d = first ? '0 : ((max_eq || max_lo) ? max_idx_q : cnt_q);
        min_idx_d = first ? '0 : ((min_eq || min_gr) ? min_idx_q : cnt_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_idx_q     <= '0;
            min_idx_q     <= '0;
            out_max_idx_q <= '0;
            out_min_idx_q <= '0;
        end else if (accept) begin
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            if (close) begin
                out_max_idx_q <= max_idx_d;
                out_min_idx_q <= min_idx_d;
            end
        end
    end

    assign out_max_idx = out_max_idx_q;
    assign out_min_idx = out_min_idx_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b1;
            out_valid_q <= 1'b0;
            max_q       <= '0;
            min_q       <= '0;
            cnt_q       <= '0;
            out_max_q   <= '0;
            out_min_q   <= '0;
            out_cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        max_q <= max_d;
                        min_q <= min_d;
                        cnt_q <= cnt_d;
                        if (close) begin
                            out_max_q   <= max_d;
                            out_min_q   <= min_d;
                            out_cnt_q   <= cnt_d;
                            out_valid_q <= 1'b1;
                            rdy_q       <= 1'b0;
                            state_q     <= S_HOLD;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        rdy_q       <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    rdy_q       <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
